// File: rtl/trap_sequencer_pkg.sv
// Shared trap-controller types: exception kinds, sequencer states and mcause codes.
package tcore_param;

    typedef enum logic [2:0] {
        NO_EXCEPTION,
        INSTR_MISALIGNED,
        ILLEGAL_INSTR,
        BREAKPOINT,
        LOAD_MISALIGNED,
        STORE_MISALIGNED,
        ECALL_M
    } exc_type_e;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        SAVE,
        REDIRECT,
        RET
    } trap_state_e;

    localparam int unsigned CAUSE_INSTR_MISALIGNED = 0;
    localparam int unsigned CAUSE_ILLEGAL_INSTR    = 2;
    localparam int unsigned CAUSE_BREAKPOINT       = 3;
    localparam int unsigned CAUSE_LOAD_MISALIGNED  = 4;
    localparam int unsigned CAUSE_STORE_MISALIGNED = 6;
    localparam int unsigned CAUSE_ECALL_M          = 11;

endpackage

// File: rtl/trap_sequencer_cause_enc.sv
// Combinational mcause encoder: exception kind or interrupt flag to an XLEN cause word.
module trap_cause_enc
    import tcore_param::*;
#(
    parameter int XLEN     = 32,
    parameter int IRQ_CODE = 11
) (
    input  exc_type_e        exc_type_i,
    input  logic             irq_i,
    output logic [XLEN-1:0]  cause_o
);

    always_comb begin
        cause_o = '0;
        if (irq_i) begin
            cause_o = {1'b1, (XLEN-1)'(IRQ_CODE)};
        end else begin
            case (exc_type_i)
                INSTR_MISALIGNED: cause_o = XLEN'(CAUSE_INSTR_MISALIGNED);
                ILLEGAL_INSTR:    cause_o = XLEN'(CAUSE_ILLEGAL_INSTR);
                BREAKPOINT:       cause_o = XLEN'(CAUSE_BREAKPOINT);
                LOAD_MISALIGNED:  cause_o = XLEN'(CAUSE_LOAD_MISALIGNED);
                STORE_MISALIGNED: cause_o = XLEN'(CAUSE_STORE_MISALIGNED);
                ECALL_M:          cause_o = XLEN'(CAUSE_ECALL_M);
                default:          cause_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / mret sequencer beside the execute stage.
// Optional TRAP_VECTORED_MTVEC_EN: vectored mtvec mode for interrupts.
//
// state    | meaning
// IDLE     | watching execute for exception, interrupt or mret
// DRAIN    | trap taken, waiting for multi-cycle ALU op to finish
// SAVE     | one-cycle mcause/mepc write strobe to the CSR file
// REDIRECT | load PC with the mtvec target
// RET      | load PC with mepc (mret)
module trap_sequencer
    import tcore_param::*;
#(
    parameter int XLEN     = 32,
    parameter int IRQ_CODE = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ex_valid_i,
    input  exc_type_e        exc_type_i,
    input  logic [XLEN-1:0]  ex_pc_i,
    input  logic             alu_stall_i,
    input  logic             irq_i,
    input  logic             mie_i,
    input  logic             mret_i,
    input  logic [XLEN-1:0]  mtvec_i,
    input  logic [XLEN-1:0]  mepc_i,
    output logic             trap_active_o,
    output logic [XLEN-1:0]  trap_cause_o,
    output logic [XLEN-1:0]  trap_mepc_o,
    output logic             stall_o,
    output logic             flush_o,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             busy_o
);

    trap_state_e      state_q;
    logic [XLEN-1:0]  cause_q;
    logic [XLEN-1:0]  mepc_q;
    logic             trap_active_q;
    logic             redirect_q;
    logic             flush_q;

    logic             exc_req;
    logic             irq_req;
    logic             trap_req;
    logic [XLEN-1:0]  cause_enc;
    logic [XLEN-1:0]  mtvec_base;
    logic [XLEN-1:0]  trap_target;
    logic             idle;

    assign idle     = (state_q == IDLE);
    assign exc_req  = ex_valid_i && (exc_type_i != NO_EXCEPTION);
    assign irq_req  = ex_valid_i && irq_i && mie_i && !exc_req;
    // Requests only count in IDLE; while busy the pending flush removes their source.
    assign trap_req = idle && (exc_req || irq_req);

    trap_cause_enc #(
        .XLEN     (XLEN),
        .IRQ_CODE (IRQ_CODE)
    ) u_cause_enc (
        .exc_type_i (exc_type_i),
        .irq_i      (irq_req),
        .cause_o    (cause_enc)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            cause_q       <= '0;
            mepc_q        <= '0;
            trap_active_q <= 1'b0;
            redirect_q    <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            trap_active_q <= 1'b0;
            redirect_q    <= 1'b0;
            flush_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trap_req) begin
                        cause_q <= cause_enc;
                        mepc_q  <= ex_pc_i;
                        if (alu_stall_i) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q       <= SAVE;
                            trap_active_q <= 1'b1;
                            flush_q       <= 1'b1;
                        end
                    end else if (mret_i) begin
                        state_q    <= RET;
                        redirect_q <= 1'b1;
                        flush_q    <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!alu_stall_i) begin
                        state_q       <= SAVE;
                        trap_active_q <= 1'b1;
                        flush_q       <= 1'b1;
                    end
                end
                SAVE: begin
                    state_q    <= REDIRECT;
                    redirect_q <= 1'b1;
                    flush_q    <= 1'b1;
                end
                REDIRECT: state_q <= IDLE;
                RET:      state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    // mtvec is read live in REDIRECT so a CSR write issued from SAVE is honoured.
    assign mtvec_base = {mtvec_i[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_MTVEC_EN
    assign trap_target = (mtvec_i[1:0] == 2'b01 && cause_q[XLEN-1])
                         ? mtvec_base + XLEN'(4 * IRQ_CODE)
                         : mtvec_base;
`else
    assign trap_target = mtvec_base;
`endif

    always_comb begin
        redirect_pc_o = '0;
        case (state_q)
            REDIRECT: redirect_pc_o = trap_target;
            RET:      redirect_pc_o = {mepc_i[XLEN-1:1], 1'b0};
            default:  redirect_pc_o = '0;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{mtvec_i[1:0], mepc_i[0]};

    assign busy_o        = !idle;
    assign stall_o       = busy_o || trap_req || (idle && mret_i);
    assign flush_o       = flush_q || trap_req;
    assign trap_active_o = trap_active_q;
    assign redirect_o    = redirect_q;
    assign trap_cause_o  = cause_q;
    assign trap_mepc_o   = mepc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: expected CSR writes and redirects queued at drive time.
module tb_trap_sequencer;
    import tcore_param::*;

    localparam int XLEN = 32;
    localparam int K_SAVE  = 1;
    localparam int K_REDIR = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ex_valid;
    exc_type_e        exc_type;
    logic [XLEN-1:0]  ex_pc;
    logic             alu_stall;
    logic             irq;
    logic             mie;
    logic             mret;
    logic [XLEN-1:0]  mtvec;
    logic [XLEN-1:0]  mepc;
    logic             trap_active;
    logic [XLEN-1:0]  trap_cause;
    logic [XLEN-1:0]  trap_mepc;
    logic             stall;
    logic             flush;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic             busy;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   nchecks = 0;
    int   nerrs = 0;

    trap_sequencer #(.XLEN(XLEN), .IRQ_CODE(11)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .ex_valid_i    (ex_valid),
        .exc_type_i    (exc_type),
        .ex_pc_i       (ex_pc),
        .alu_stall_i   (alu_stall),
        .irq_i         (irq),
        .mie_i         (mie),
        .mret_i        (mret),
        .mtvec_i       (mtvec),
        .mepc_i        (mepc),
        .trap_active_o (trap_active),
        .trap_cause_o  (trap_cause),
        .trap_mepc_o   (trap_mepc),
        .stall_o       (stall),
        .flush_o       (flush),
        .redirect_o    (redirect),
        .redirect_pc_o (redirect_pc),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_trap(input int save_off, input logic [31:0] cause,
                             input logic [31:0] pc, input logic [31:0] target);
        exp_q.push_back('{K_SAVE,  cyc + save_off,     cause, pc});
        exp_q.push_back('{K_REDIR, cyc + save_off + 1, target, 32'h0});
    endtask

    task automatic clear_inputs();
        ex_valid  = 1'b0;
        exc_type  = NO_EXCEPTION;
        alu_stall = 1'b0;
        irq       = 1'b0;
        mie       = 1'b0;
        mret      = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'b0, busy}, 32'h0);
    endtask

    // Output monitor: every CSR write strobe and redirect must match the queue head.
    always @(negedge clk) begin
        if (rst_n && trap_active) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_save", exp_q.size(), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("save_kind", K_SAVE, mon_e.kind);
                chk("save_cycle", cyc, mon_e.cyc);
                chk("save_cause", trap_cause, mon_e.a);
                chk("save_mepc", trap_mepc, mon_e.b);
                chk("save_flush", {31'b0, flush}, 32'h1);
            end
        end
        if (rst_n && redirect) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_redirect", exp_q.size(), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("redir_kind", K_REDIR, mon_e.kind);
                chk("redir_cycle", cyc, mon_e.cyc);
                chk("redir_pc", redirect_pc, mon_e.a);
                chk("redir_flush", {31'b0, flush}, 32'h1);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        ex_pc = '0;
        mtvec = 32'h80;
        mepc  = '0;
        #23;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_trap_active", {31'b0, trap_active}, 32'h0);
        chk("rst_redirect", {31'b0, redirect}, 32'h0);
        chk("rst_cause", trap_cause, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        rst_n = 1'b1;

        // 1: illegal instruction, no ALU stall
        @(posedge clk); #1;
        ex_valid = 1'b1; exc_type = ILLEGAL_INSTR; ex_pc = 32'h100; mtvec = 32'h80;
        push_trap(1, 32'd2, 32'h100, 32'h80);
        @(negedge clk);
        chk("t1_detect_stall", {31'b0, stall}, 32'h1);
        chk("t1_detect_flush", {31'b0, flush}, 32'h1);
        chk("t1_detect_busy", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t1_busy_n3", {31'b0, busy}, 32'h0);

        // 2: ecall while ALU op in flight for 5 cycles
        @(posedge clk); #1;
        ex_valid = 1'b1; exc_type = ECALL_M; ex_pc = 32'h1F0; alu_stall = 1'b1;
        push_trap(6, 32'd11, 32'h1F0, 32'h80);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin ex_valid = 1'b0; exc_type = NO_EXCEPTION; end
            if (i == 5) alu_stall = 1'b0;
            @(negedge clk);
            chk("t2_drain_stall", {31'b0, stall}, 32'h1);
            chk("t2_drain_flush", {31'b0, flush}, 32'h0);
            chk("t2_drain_busy", {31'b0, busy}, 32'h1);
        end
        wait_idle(10);

        // 3: external interrupt enabled, then masked
        @(posedge clk); #1;
        ex_valid = 1'b1; irq = 1'b1; mie = 1'b1; ex_pc = 32'h200;
        push_trap(1, 32'h8000000B, 32'h200, 32'h80);
        @(posedge clk); #1;
        clear_inputs();
        wait_idle(10);
        @(posedge clk); #1;
        ex_valid = 1'b1; irq = 1'b1; mie = 1'b0; ex_pc = 32'h204;
        @(negedge clk);
        chk("t3_masked_stall", {31'b0, stall}, 32'h0);
        chk("t3_masked_flush", {31'b0, flush}, 32'h0);
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        chk("t3_masked_busy", {31'b0, busy}, 32'h0);

        // 4: breakpoint, interrupt and mret together; exception wins, mret dropped
        @(posedge clk); #1;
        ex_valid = 1'b1; exc_type = BREAKPOINT; irq = 1'b1; mie = 1'b1; mret = 1'b1;
        ex_pc = 32'h300; mepc = 32'h777;
        push_trap(1, 32'd3, 32'h300, 32'h80);
        @(posedge clk); #1;
        clear_inputs();
        wait_idle(10);

        // mtvec written during SAVE is what REDIRECT uses; requests in SAVE ignored
        @(posedge clk); #1;
        ex_valid = 1'b1; exc_type = STORE_MISALIGNED; ex_pc = 32'h120; mtvec = 32'h80;
        push_trap(1, 32'd6, 32'h120, 32'h400);
        @(posedge clk); #1;
        mtvec = 32'h400; exc_type = ILLEGAL_INSTR; ex_pc = 32'h999;
        @(posedge clk); #1;
        clear_inputs();
        wait_idle(10);
        mtvec = 32'h80;

        // 5: mret to mepc with bit 0 cleared
        @(posedge clk); #1;
        mret = 1'b1; mepc = 32'h345;
        exp_q.push_back('{K_REDIR, cyc + 1, 32'h344, 32'h0});
        @(negedge clk);
        chk("t5_mret_stall", {31'b0, stall}, 32'h1);
        @(posedge clk); #1;
        mret = 1'b0;
        wait_idle(10);

        // reset pulsed in DRAIN aborts with no CSR write or redirect
        @(posedge clk); #1;
        ex_valid = 1'b1; exc_type = ILLEGAL_INSTR; ex_pc = 32'h500; alu_stall = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0; exc_type = NO_EXCEPTION;
        @(negedge clk);
        chk("t5_in_drain", {31'b0, busy}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", {31'b0, busy}, 32'h0);
        chk("t5_rst_stall", {31'b0, stall}, 32'h0);
        chk("t5_rst_flush", {31'b0, flush}, 32'h0);
        chk("t5_rst_active", {31'b0, trap_active}, 32'h0);
        chk("t5_rst_redirect", {31'b0, redirect}, 32'h0);
        chk("t5_rst_cause", trap_cause, 32'h0);
        chk("t5_rst_mepc", trap_mepc, 32'h0);
        alu_stall = 1'b0;
        #4 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_after_rst_busy", {31'b0, busy}, 32'h0);

        // 6: mtvec mode bits
        @(posedge clk); #1;
        ex_valid = 1'b1; irq = 1'b1; mie = 1'b1; ex_pc = 32'h600; mtvec = 32'h81;
`ifdef TRAP_VECTORED_MTVEC_EN
        push_trap(1, 32'h8000000B, 32'h600, 32'hAC);
`else
        push_trap(1, 32'h8000000B, 32'h600, 32'h80);
`endif
        @(posedge clk); #1;
        clear_inputs();
        wait_idle(10);
        @(posedge clk); #1;
        ex_valid = 1'b1; exc_type = LOAD_MISALIGNED; ex_pc = 32'h604;
        push_trap(1, 32'd4, 32'h604, 32'h80);
        @(posedge clk); #1;
        clear_inputs();
        wait_idle(10);

        repeat (3) @(negedge clk);
        chk("sb_drain", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Machine-mode trap controller beside the execute stage.
- Detects a synchronous exception, or an enabled external interrupt, on the instruction in execute, then sequences the full trap entry:
  - pipeline stall and flush,
  - drain of any multi-cycle ALU operation,
  - one-cycle CSR trap write (mcause/mepc),
  - PC redirect to mtvec.
- Also sequences mret return to mepc.
- Sole driver of the trap_active/trap_cause/trap_mepc inputs of the CSR register file.

Parameters:
- XLEN, 32, datapath width.
- IRQ_CODE, 11, interrupt cause code (machine external interrupt).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ex_valid_i  in  1  a valid instruction is in execute
- exc_type_i  in  exc_type_e  exception flagged by execute
- ex_pc_i  in  XLEN  PC of the instruction in execute
- alu_stall_i  in  1  multi-cycle ALU operation in flight
- irq_i  in  1  external interrupt request, level-sensitive
- mie_i  in  1  mstatus.MIE global enable
- mret_i  in  1  valid mret in execute
- mtvec_i  in  XLEN  current mtvec
- mepc_i  in  XLEN  current mepc
- trap_active_o  out  1  CSR trap-write strobe
- trap_cause_o  out  XLEN  mcause value
- trap_mepc_o  out  XLEN  mepc value
- stall_o  out  1  freeze fetch/decode/execute
- flush_o  out  1  kill IF/ID/EX contents
- redirect_o  out  1  load redirect_pc_o into PC
- redirect_pc_o  out  XLEN  redirect target
- busy_o  out  1  sequencer not IDLE

Behaviour:
- Interface: one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Reset state is IDLE. All outputs reset to 0. Cause and mepc registers reset to 0.
- Reset asserted mid-sequence aborts immediately to IDLE. No CSR write and no redirect are issued.

Trap request conditions, evaluated in IDLE only:
- exc_req = ex_valid_i && exc_type_i != NO_EXCEPTION
- irq_req = ex_valid_i && irq_i && mie_i && !exc_req
- Exception has priority over interrupt.
- Exception or interrupt has priority over mret. An mret in the same cycle is discarded.

Cause encoding:
- INSTR_MISALIGNED=0, ILLEGAL_INSTR=2, BREAKPOINT=3, LOAD_MISALIGNED=4, STORE_MISALIGNED=6, ECALL_M=11.
- Interrupt cause = {1'b1, IRQ_CODE zero-extended to XLEN-1}.
- mepc = ex_pc_i for both exceptions and interrupts. The interrupted instruction re-executes.

States:
- IDLE
  - On a trap request: latch cause and mepc.
  - Go to DRAIN if alu_stall_i, else SAVE.
  - On mret_i with no trap request: go to RET.
  - stall_o and flush_o are asserted combinationally in the detect cycle.
- DRAIN
  - stall_o=1, flush_o=0.
  - Stay while alu_stall_i. When it drops, go to SAVE.
- SAVE
  - trap_active_o=1 for exactly one cycle.
  - trap_cause_o/trap_mepc_o = latched values. flush_o=1.
  - Go to REDIRECT.
- REDIRECT
  - redirect_o=1, flush_o=1.
  - redirect_pc_o = {mtvec_i[XLEN-1:2], 2'b00}.
  - Go to IDLE.
- RET
  - redirect_o=1, flush_o=1.
  - redirect_pc_o = {mepc_i[XLEN-1:1], 1'b0}.
  - Go to IDLE.

Outputs:
- busy_o = (state != IDLE).
- stall_o = busy_o || trap request || mret_i.
- trap_cause_o/trap_mepc_o hold their latched values outside SAVE. The CSR file qualifies them with trap_active_o.

Latency:
- Exception with no stall: detect at cycle N, SAVE at N+1, redirect at N+2.
- mret: redirect at N+1.

Boundaries:
- Requests arriving while busy are ignored. The flush removes their source.
- irq_i deasserting after detection does not abort the sequence.
- mtvec_i is sampled in the REDIRECT cycle, so a CSR write from SAVE is visible.

Optional Feature:
- Macro: TRAP_VECTORED_MTVEC_EN.
- Defined: if mtvec_i[1:0]==2'b01 and the latched cause is an interrupt, target = base + 4*IRQ_CODE. Exceptions always go to base.
- Undefined: mtvec mode bits are ignored and all traps go to base.

Decomposition:
- Shared package tcore_param:
  - trap_state_e {IDLE, DRAIN, SAVE, REDIRECT, RET}
  - cause code localparams, e.g. CAUSE_ILLEGAL_INSTR
  - exc_type_e, already present
- One natural sub-module: trap_cause_enc, a combinational map from exc_type_e and interrupt flag to XLEN mcause.

Test Plan:
1. exc_type_i=ILLEGAL_INSTR, ex_pc_i=0x100, mtvec_i=0x80, no stall -> trap_active_o at N+1 with cause 2, mepc 0x100; redirect_o at N+2 to 0x80; busy_o low at N+3.
2. ECALL detected while alu_stall_i is held high 5 cycles -> DRAIN for 5 cycles with stall_o=1 and trap_active_o=0; then SAVE with cause 11; then redirect.
3. irq_i=1, mie_i=1, ex_pc_i=0x200 -> cause 0x8000000B, mepc 0x200. Repeat with mie_i=0 -> no trap, stall_o=0.
4. Same-cycle BREAKPOINT, irq_i and mret_i -> cause 3. No RET and a single redirect.
5. mret_i with mepc_i=0x345 -> redirect_o at N+1 to 0x344. Then rst_ni pulsed low during DRAIN -> all outputs 0, state IDLE, no trap_active_o.
6. With TRAP_VECTORED_MTVEC_EN defined: mtvec_i=0x81 plus interrupt -> target 0xAC. mtvec_i=0x81 plus LOAD_MISALIGNED -> target 0x80.
